// File: rtl/tt_sampler_pkg.sv
// Shared types and helpers for the truth-table sampler: FSM state encoding,
// the largest supported gate width and the table-width helper.
package tt_sampler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_t;

    localparam int TT_MAX_INPUTS = 8;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter for the per-vector settle dwell; term is high once the
// dwell has expired so the FSM only has to load it and let it run.
module tt_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic term
);

    localparam logic [7:0] LOAD_VAL = 8'(SETTLE_CYCLES - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != 8'd0)) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign term = (cnt == 8'd0);

endmodule

// File: rtl/truth_table_sampler.sv
// Sweeps every input vector of an N-input gate, waits a settle time per vector
// and samples the gate output into a 2^N-bit truth table.
// Optional TT_SAMPLER_COMPARE_EN adds on-the-fly comparison against an expected table.
module truth_table_sampler
    import tt_sampler_pkg::*;
#(
    parameter int N_INPUTS      = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic [N_INPUTS-1:0]               stim,
    input  logic                              dut_out,
    output logic [tt_width(N_INPUTS)-1:0]     truth_table,
    output logic                              table_valid
`ifdef TT_SAMPLER_COMPARE_EN
    ,
    input  logic [tt_width(N_INPUTS)-1:0]     expected_table,
    output logic                              mismatch,
    output logic [N_INPUTS-1:0]               first_fail_idx
`endif
);

    localparam int                TW       = tt_width(N_INPUTS);
    localparam logic [N_INPUTS:0] LAST_IDX = (N_INPUTS + 1)'(TW - 1);

    tt_state_t         state;
    tt_state_t         state_d;
    logic [N_INPUTS:0] idx;
    logic              accept;
    logic              last_vec;
    logic              timer_load;
    logic              timer_en;
    logic              timer_term;

    assign last_vec = (idx == LAST_IDX);

    tt_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .en    (timer_en),
        .term  (timer_term)
    );

    always_comb begin
        state_d    = state;
        accept     = 1'b0;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    timer_load = 1'b1;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (timer_term) state_d = SAMPLE;
                else            timer_en = 1'b1;
            end
            SAMPLE: begin
                if (last_vec) begin
                    state_d = DONE;
                end else begin
                    timer_load = 1'b1;
                    state_d    = SETTLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // busy/done are decoded from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            stim        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truth_table <= '0;
            table_valid <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= (state_d == SETTLE) || (state_d == SAMPLE);
            done  <= (state_d == DONE);
            if (accept) begin
                idx         <= '0;
                stim        <= '0;
                truth_table <= '0;
                table_valid <= 1'b0;
            end
            if (state == SAMPLE) begin
                truth_table[idx[N_INPUTS-1:0]] <= dut_out;
                if (last_vec) begin
                    stim        <= '0;
                    table_valid <= 1'b1;
                end else begin
                    idx  <= idx + 1'b1;
                    stim <= stim + 1'b1;
                end
            end
        end
    end

`ifdef TT_SAMPLER_COMPARE_EN
    logic [TW-1:0] exp_q;

    // only the first disagreeing vector is recorded; later ones leave it untouched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_q          <= '0;
            mismatch       <= 1'b0;
            first_fail_idx <= '0;
        end else if (accept) begin
            exp_q          <= expected_table;
            mismatch       <= 1'b0;
            first_fail_idx <= '0;
        end else if ((state == SAMPLE) && !mismatch &&
                     (dut_out != exp_q[idx[N_INPUTS-1:0]])) begin
            mismatch       <= 1'b1;
            first_fail_idx <= idx[N_INPUTS-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_sampler.sv
// Bench for truth_table_sampler: three instances (3-input/settle 2, 2-input/settle 1,
// 3-input/settle 4) checked every cycle against a sweep-timing model.
module tb_truth_table_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a, start_b, start_c;
    logic gate_sel;

    logic       busy_a, done_a, tv_a, dut_a;
    logic [2:0] stim_a;
    logic [7:0] tt_a;
    logic       busy_b, done_b, tv_b, dut_b;
    logic [1:0] stim_b;
    logic [3:0] tt_b;
    logic       busy_c, done_c, tv_c, dut_c;
    logic [2:0] stim_c;
    logic [7:0] tt_c;

`ifdef TT_SAMPLER_COMPARE_EN
    logic [7:0] exp_tab;
    logic       mism_a;
    logic [2:0] ffi_a;
`endif

    // gates under test: NAND3 or NOR3, AND2, and a wire from stim[0]
    assign dut_a = gate_sel ? ~|stim_a : ~&stim_a;
    assign dut_b = &stim_b;
    assign dut_c = stim_c[0];

    truth_table_sampler #(.N_INPUTS(3), .SETTLE_CYCLES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .stim(stim_a), .dut_out(dut_a), .truth_table(tt_a), .table_valid(tv_a)
`ifdef TT_SAMPLER_COMPARE_EN
        , .expected_table(exp_tab), .mismatch(mism_a), .first_fail_idx(ffi_a)
`endif
    );

    truth_table_sampler #(.N_INPUTS(2), .SETTLE_CYCLES(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .stim(stim_b), .dut_out(dut_b), .truth_table(tt_b), .table_valid(tv_b)
`ifdef TT_SAMPLER_COMPARE_EN
        , .expected_table(4'b1000), .mismatch(), .first_fail_idx()
`endif
    );

    truth_table_sampler #(.N_INPUTS(3), .SETTLE_CYCLES(4)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
        .stim(stim_c), .dut_out(dut_c), .truth_table(tt_c), .table_valid(tv_c)
`ifdef TT_SAMPLER_COMPARE_EN
        , .expected_table(8'hAA), .mismatch(), .first_fail_idx()
`endif
    );

    int n_pass = 0;
    int n_chk  = 0;
    logic chk_on = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int           n_of [3] = '{3, 2, 3};
    int           s_of [3] = '{2, 1, 4};
    int           mt   [3];            // cycles since start accepted, 0 when idle
    logic         hv   [3];            // held table_valid while idle
    logic [255:0] ht   [3];            // held table while idle
    logic [255:0] full [3];            // complete table of the gate being swept

    function automatic logic gate_bit(input int i, input logic sel, input int k);
        case (i)
            0:       return sel ? (k == 0) : (k != 7);
            1:       return (k == 3);
            default: return (k % 2) == 1;
        endcase
    endfunction

    function automatic logic [255:0] full_table(input int i, input logic sel);
        logic [255:0] t = '0;
        for (int k = 0; k < (1 << n_of[i]); k++) t[k] = gate_bit(i, sel, k);
        return t;
    endfunction

    function automatic int done_t(input int i);
        return (1 << n_of[i]) * (s_of[i] + 1) + 1;
    endfunction

    function automatic logic start_of(input int i);
        case (i)
            0:       return start_a;
            1:       return start_b;
            default: return start_c;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                mt[i] = 0; hv[i] = 1'b0; ht[i] = '0;
            end else if (mt[i] == 0) begin
                if (start_of(i)) begin
                    mt[i] = 1; hv[i] = 1'b0; ht[i] = '0;
                    full[i] = full_table(i, gate_sel);
                end
            end else if (mt[i] == done_t(i)) begin
                mt[i] = 0; hv[i] = 1'b1; ht[i] = full[i];
            end else begin
                mt[i] = mt[i] + 1;
            end
        end
    end

    // single compare process: every instance, every cycle
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                logic         eb, ed, ev, ab, ad, av;
                int           es, as_, m;
                logic [255:0] et, at, one;
                one = 256'd1;
                if (mt[i] == 0) begin
                    eb = 0; ed = 0; es = 0; ev = hv[i]; et = ht[i];
                end else if (mt[i] == done_t(i)) begin
                    eb = 0; ed = 1; es = 0; ev = 1; et = full[i];
                end else begin
                    m  = (mt[i] - 1) / (s_of[i] + 1);
                    eb = 1; ed = 0; es = m; ev = 0;
                    et = full[i] & ((one << m) - one);
                end
                case (i)
                    0:       begin ab = busy_a; ad = done_a; as_ = int'(stim_a); av = tv_a; at = 256'(tt_a); end
                    1:       begin ab = busy_b; ad = done_b; as_ = int'(stim_b); av = tv_b; at = 256'(tt_b); end
                    default: begin ab = busy_c; ad = done_c; as_ = int'(stim_c); av = tv_c; at = 256'(tt_c); end
                endcase
                chk($sformatf("u%0d busy t=%0d", i, mt[i]),  256'(ab),  256'(eb));
                chk($sformatf("u%0d done t=%0d", i, mt[i]),  256'(ad),  256'(ed));
                chk($sformatf("u%0d stim t=%0d", i, mt[i]),  256'(as_), 256'(es));
                chk($sformatf("u%0d valid t=%0d", i, mt[i]), 256'(av),  256'(ev));
                chk($sformatf("u%0d table t=%0d", i, mt[i]), at,        et);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [1:0] seq_b [0:15];

    task automatic set_start(input int i, input logic v);
        case (i)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    function automatic logic done_of(input int i);
        case (i)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    // cyc = cycle (counted from the accepting edge) in which done is seen,
    // or the cycle after the reset pulse when rst_at > 0
    task automatic sweep(input int i, input int repulse, input int rst_at, output int cyc);
        int c;
        cyc = -1;
        @(negedge clk); set_start(i, 1'b1);
        @(negedge clk); set_start(i, 1'b0);
        c = 1;
        while (c < 200) begin
            if (i == 1 && c < 16) seq_b[c] = stim_b;
            if (done_of(i)) begin cyc = c; break; end
            if (c == repulse)          set_start(i, 1'b1);
            else if (c == repulse + 1) set_start(i, 1'b0);
            if (c == rst_at) rst_n = 1'b0;
            if (rst_at > 0 && c == rst_at + 1) begin rst_n = 1'b1; cyc = c; break; end
            @(negedge clk);
            c++;
        end
        if (cyc < 0) chk($sformatf("u%0d sweep timeout", i), 256'(c), 256'(0));
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; gate_sel = 1'b0;
`ifdef TT_SAMPLER_COMPARE_EN
        exp_tab = 8'h7F;
`endif
        repeat (3) @(negedge clk);
        chk("reset busy",  256'(busy_a), 256'(0));
        chk("reset done",  256'(done_a), 256'(0));
        chk("reset stim",  256'(stim_a), 256'(0));
        chk("reset table", 256'(tt_a),   256'(0));
        chk("reset valid", 256'(tv_a),   256'(0));
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // NAND3, defaults
        sweep(0, -10, 0, cyc);
        chk("nand3 done cycle", 256'(cyc),    256'(25));
        chk("nand3 table",      256'(tt_a),   256'(8'h7F));
        chk("nand3 valid",      256'(tv_a),   256'(1));
        chk("nand3 stim",       256'(stim_a), 256'(0));
`ifdef TT_SAMPLER_COMPARE_EN
        chk("nand3 no mismatch", 256'(mism_a), 256'(0));
`endif
        repeat (3) @(negedge clk);
        chk("valid held idle", 256'(tv_a), 256'(1));

        // start re-pulsed mid-sweep is ignored
        sweep(0, 10, 0, cyc);
        chk("repulse done cycle", 256'(cyc),  256'(25));
        chk("repulse table",      256'(tt_a), 256'(8'h7F));
        repeat (2) @(negedge clk);

        // reset at cycle 12 aborts the sweep
        sweep(0, -10, 12, cyc);
        chk("abort busy",  256'(busy_a), 256'(0));
        chk("abort table", 256'(tt_a),   256'(0));
        chk("abort stim",  256'(stim_a), 256'(0));
        chk("abort valid", 256'(tv_a),   256'(0));
        sweep(0, -10, 0, cyc);
        chk("post-reset done cycle", 256'(cyc),  256'(25));
        chk("post-reset table",      256'(tt_a), 256'(8'h7F));

        // AND2, N=2, settle 1
        sweep(1, -10, 0, cyc);
        chk("and2 done cycle", 256'(cyc),  256'(9));
        chk("and2 table",      256'(tt_b), 256'(4'b1000));
        chk("and2 stim seq",   256'({seq_b[1], seq_b[2], seq_b[3], seq_b[4],
                                      seq_b[5], seq_b[6], seq_b[7], seq_b[8]}), 256'(16'h05AF));

        // dut_out = stim[0], settle 4
        sweep(2, -10, 0, cyc);
        chk("stim0 done cycle", 256'(cyc),  256'(41));
        chk("stim0 table",      256'(tt_c), 256'(8'hAA));

`ifdef TT_SAMPLER_COMPARE_EN
        // NOR3 against an expected NAND3 table
        repeat (2) @(negedge clk);
        gate_sel = 1'b1;
        sweep(0, -10, 0, cyc);
        chk("nor3 done cycle",  256'(cyc),    256'(25));
        chk("nor3 table",       256'(tt_a),   256'(8'h01));
        chk("nor3 mismatch",    256'(mism_a), 256'(1));
        chk("nor3 first fail",  256'(ffi_a),  256'(1));
`endif

        repeat (3) @(negedge clk);
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/truth_table_sampler.md
# truth_table_sampler

Sequential characterizer for combinational logic under test. It walks every input vector of an N-input gate in ascending binary order and waits a programmable settle time per vector. It then samples the gate's single output and assembles the full 2^N-bit truth table. It sits opposite a case-statement truth-table module: that block maps inputs to an output, while this block drives the inputs and reads the function back as a table that the netlist flow can compare against its specification.

## Interface
Parameters:
- N_INPUTS, default 3: number of gate inputs; legal range 1..8.
- SETTLE_CYCLES, default 2: cycles each vector is held before sampling; legal range 1..255.

Ports:
- clk  in  1: single clock; all logic on its rising edge.
- rst_n  in  1: synchronous, active-low reset.
- start  in  1: begin a sweep; honoured only in IDLE.
- busy  out  1: high from the cycle after start is accepted through the last SAMPLE cycle.
- done  out  1: one-cycle pulse when the table is complete.
- stim  out  N_INPUTS: input vector driven to the gate. MSB maps to the first port in the gate's case concatenation.
- dut_out  in  1: gate output.
- truth_table  out  2^N_INPUTS: bit k holds the gate output for stim == k.
- table_valid  out  1: truth_table holds a complete sweep.

## Operation
- Reset values: busy=0, done=0, stim=0, truth_table=0, table_valid=0, FSM in IDLE.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 latches idx=0, stim=0 and cnt=0, clears truth_table and table_valid, sets busy, and moves to SETTLE.
  - start=0 stays in IDLE.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1, move to SAMPLE.
- SAMPLE:
  - Writes truth_table[idx] <= dut_out.
  - If idx==2^N_INPUTS-1, move to DONE.
  - Otherwise idx++, stim <= idx+1, cnt <= 0, and move to SETTLE.
- DONE:
  - done=1 and table_valid=1 (both registered, visible this cycle); busy=0; stim returns to 0.
  - Next cycle returns to IDLE with done=0.
  - table_valid stays high until the next accepted start or reset.
- start asserted while busy, or during the DONE cycle, is ignored. It is not queued.
- stim changes only on the SAMPLE→SETTLE transition. It is stable through every SETTLE and SAMPLE cycle of its vector.
- idx width is N_INPUTS+1 bits, so the terminal compare never wraps.
- Reset asserted mid-sweep: on the next edge all outputs return to reset values. The partial table is discarded.

## Timing
- Per vector: SETTLE_CYCLES + 1 cycles.
- start accepted at edge 0:
  - busy is high in cycle 1.
  - Vector k is sampled in cycle (k+1)(SETTLE_CYCLES+1).
  - done is high in cycle 2^N_INPUTS·(SETTLE_CYCLES+1) + 1.
- Defaults (N_INPUTS=3, SETTLE_CYCLES=2): done in cycle 25.
- dut_out must be valid by the SAMPLE cycle edge; the block provides no input synchronizer.

## Configuration
- TT_SAMPLER_COMPARE_EN defined:
  - Adds input expected_table (2^N_INPUTS bits) and outputs mismatch (1 bit) and first_fail_idx (N_INPUTS bits), all reset to 0.
  - expected_table is captured at start acceptance.
  - In each SAMPLE cycle where dut_out != expected bit and mismatch is still 0, the next edge sets mismatch=1 and first_fail_idx=idx.
  - Both outputs are cleared on the next accepted start.
- TT_SAMPLER_COMPARE_EN undefined: none of these ports or registers exist. Behaviour is otherwise identical.

## Structure
- Package tt_sampler_pkg: state enum (IDLE, SETTLE, SAMPLE, DONE), TT_MAX_INPUTS=8, and the width function tt_width(n)=1<<n.
- Sub-module tt_settle_timer: loadable down-counter with a terminal flag. It is used for the SETTLE dwell and keeps the FSM free of counter arithmetic.

## Test plan
- NAND3 model on stim, defaults, start pulse → done in cycle 25, truth_table=8'h7F, table_valid=1, stim returned to 0.
- AND2 model, N_INPUTS=2, SETTLE_CYCLES=1 → truth_table=4'b1000, done in cycle 9; stim observed as 0,1,2,3, each held 2 cycles.
- start re-pulsed at cycle 10 of a sweep → ignored; done still in cycle 25 with an identical table.
- rst_n low at cycle 12 for 1 cycle → next edge busy=0, truth_table=0, stim=0; a fresh start then completes normally.
- dut_out tied to stim[0] with SETTLE_CYCLES=4 → truth_table=8'hAA, done in cycle 41.
- COMPARE_EN with expected_table=8'h7F and a NOR3 model → mismatch=1, first_fail_idx=1, truth_table=8'h01.
